// File: rtl/sram_arbiter.sv
// Three-port round-robin arbiter that gates traffic until the SDRAM controller has initialised,
// then turns each request into a fixed-length slot with a level strobe and a one-cycle ack.
module sram_arbiter #(
    parameter int STARTUP_CYCLES = 10240,
    parameter int SLOT_CYCLES    = 32,
    parameter int STROBE_CYCLES  = 4
) (
    input  logic        clk_sdram,
    input  logic        init_n,
    input  logic [2:0]  p_req,
    input  logic [2:0]  p_we,
    input  logic [74:0] p_addr,
    input  logic [23:0] p_din,
    output logic [2:0]  p_ack,
    output logic [7:0]  p_dout,
    output logic        busy,
    output logic [24:0] sram_addr,
    output logic [7:0]  sram_din,
    output logic        sram_rd,
    output logic        sram_we,
    input  logic [7:0]  sram_dout
);

    localparam int SUW = $clog2(STARTUP_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_IDLE,
        ST_STROBE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [SUW-1:0]  su_cnt_q, su_cnt_d;
    logic [7:0]      slot_cnt_q, slot_cnt_d;
    logic [1:0]      last_q, last_d;
    logic [1:0]      win_q, win_d;
    logic            we_q, we_d;
    logic [24:0]     addr_q, addr_d;
    logic [7:0]      din_q, din_d;
    logic [7:0]      dout_q, dout_d;
    logic [1:0]      pick;
    logic [1:0]      cand;

    function automatic logic [1:0] wrap3(input logic [2:0] v);
        logic [2:0] t;
        t = (v >= 3'd3) ? (v - 3'd3) : v;
        return t[1:0];
    endfunction

    // Scan lowest priority first so the highest-priority requester is the last to overwrite pick.
    always_comb begin
        pick = last_q;
        cand = last_q;
        for (int i = 3; i >= 1; i--) begin
            cand = wrap3({1'b0, last_q} + 3'(i));
            if (p_req[cand]) pick = cand;
        end
    end

    always_comb begin
        state_d    = state_q;
        su_cnt_d   = su_cnt_q;
        slot_cnt_d = slot_cnt_q;
        last_d     = last_q;
        win_d      = win_q;
        we_d       = we_q;
        addr_d     = addr_q;
        din_d      = din_q;
        dout_d     = dout_q;
        case (state_q)
            ST_STARTUP: begin
                su_cnt_d = su_cnt_q + SUW'(1);
                if (su_cnt_q == SUW'(STARTUP_CYCLES - 1)) begin
                    state_d  = ST_IDLE;
                    su_cnt_d = '0;
                end
            end
            ST_IDLE: begin
                if (|p_req) begin
                    state_d    = ST_STROBE;
                    last_d     = pick;
                    win_d      = pick;
                    we_d       = p_we[pick];
                    addr_d     = p_addr[25*pick +: 25];
                    din_d      = p_din[8*pick +: 8];
                    slot_cnt_d = 8'd1;
                end
            end
            ST_STROBE: begin
                slot_cnt_d = slot_cnt_q + 8'd1;
                if (slot_cnt_q == 8'(STROBE_CYCLES)) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                slot_cnt_d = slot_cnt_q + 8'd1;
                // Read data is captured on entry to DONE so it is valid alongside the ack.
                if (slot_cnt_q == 8'(SLOT_CYCLES)) begin
                    state_d = ST_DONE;
                    if (!we_q) dout_d = sram_dout;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_STARTUP;
        endcase
    end

    always_ff @(posedge clk_sdram or negedge init_n) begin
        if (!init_n) begin
            state_q    <= ST_STARTUP;
            su_cnt_q   <= '0;
            slot_cnt_q <= '0;
            last_q     <= 2'd2;
            win_q      <= 2'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            su_cnt_q   <= su_cnt_d;
            slot_cnt_q <= slot_cnt_d;
            last_q     <= last_d;
            win_q      <= win_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            dout_q     <= dout_d;
        end
    end

    assign p_ack     = (state_q == ST_DONE) ? (3'(1) << win_q) : 3'b000;
    assign p_dout    = dout_q;
    assign busy      = (state_q != ST_IDLE);
    assign sram_addr = addr_q;
    assign sram_din  = din_q;
    assign sram_rd   = (state_q == ST_STROBE) && !we_q;
    assign sram_we   = (state_q == ST_STROBE) && we_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a slot-timing model predicts every output each cycle from the grant
// time, plus directed scenarios with literal expectations and a randomized traffic phase.
module tb_sram_arbiter;
    localparam int SU = 10240, SL = 32, ST = 4;

    logic        clk_sdram = 1'b0;
    logic        init_n = 1'b0;
    logic [2:0]  p_req = '0, p_we = '0;
    logic [74:0] p_addr = '0;
    logic [23:0] p_din = '0;
    logic [2:0]  p_ack;
    logic [7:0]  p_dout;
    logic        busy;
    logic [24:0] sram_addr;
    logic [7:0]  sram_din;
    logic        sram_rd, sram_we;
    logic [7:0]  sram_dout;
    logic [7:0]  key = '0;

    sram_arbiter dut (
        .clk_sdram(clk_sdram), .init_n(init_n), .p_req(p_req), .p_we(p_we),
        .p_addr(p_addr), .p_din(p_din), .p_ack(p_ack), .p_dout(p_dout), .busy(busy),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_rd(sram_rd), .sram_we(sram_we),
        .sram_dout(sram_dout)
    );

    always #4 clk_sdram = ~clk_sdram;

    // Controller stand-in: read data is a keyed function of the address.
    assign sram_dout = sram_addr[7:0] ^ key;

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
        end
    endtask

    // Model state: slot timing is measured from the grant cycle g.
    int          cyc = 0, g = 0, win = 0, last = 2, k;
    bit          act = 0, m_wr = 0;
    logic [24:0] m_addr = '0;
    logic [7:0]  m_din = '0, m_dout = '0;
    logic [2:0]  e_ack;
    bit          e_rd, e_we, e_busy;
    int          best, nn;

    // Observation records for the directed checks.
    int ack_cnt = 0, first_rise = -1, last_rise = 0, strobe_len = 0, low_run = 0, min_gap = 1000;
    bit seen_strobe = 0, prev_strobe = 0, strobe;
    int ack_port[$], ack_cyc[$];

    always @(negedge clk_sdram) begin
        if (!init_n) begin
            cyc = 0; act = 0; last = 2; m_addr = '0; m_din = '0; m_dout = '0;
            first_rise = -1; seen_strobe = 0;
            chk("rst_ack", p_ack, 0);
            chk("rst_rd", sram_rd, 0);
            chk("rst_we", sram_we, 0);
            chk("rst_busy", busy, 1);
            chk("rst_addr", sram_addr, 0);
            chk("rst_din", sram_din, 0);
            chk("rst_dout", p_dout, 0);
        end else begin
            k      = act ? cyc - g : -1;
            e_rd   = act && k >= 1 && k <= ST && !m_wr;
            e_we   = act && k >= 1 && k <= ST && m_wr;
            e_ack  = (act && k == SL + 1) ? (3'(1) << win) : 3'b000;
            e_busy = (cyc < SU) || (act && k >= 1);
            chk("ack", p_ack, e_ack);
            chk("rd", sram_rd, e_rd);
            chk("we", sram_we, e_we);
            chk("busy", busy, e_busy);
            chk("addr", sram_addr, m_addr);
            chk("din", sram_din, m_din);
            chk("dout", p_dout, m_dout);

            strobe = sram_rd | sram_we;
            if (strobe) begin
                if (!prev_strobe) begin
                    if (first_rise < 0) first_rise = cyc;
                    if (seen_strobe && low_run < min_gap) min_gap = low_run;
                    last_rise  = cyc;
                    strobe_len = 0;
                end
                strobe_len++;
                low_run     = 0;
                seen_strobe = 1;
            end else begin
                low_run++;
            end
            if (p_ack != 3'b000) begin
                ack_cnt++;
                ack_port.push_back(p_ack[1] ? 1 : (p_ack[2] ? 2 : 0));
                ack_cyc.push_back(cyc);
            end

            if (act && k == SL && !m_wr) m_dout = m_addr[7:0] ^ key;
            if (act && k == SL + 1) begin
                act = 0;
            end else if (!act && cyc >= SU && p_req != 3'b000) begin
                best = -1;
                for (int d = 1; d <= 3; d++) begin
                    nn = (last + d) % 3;
                    if (best < 0 && p_req[nn]) best = nn;
                end
                act = 1; g = cyc; win = best; last = best;
                m_wr   = p_we[best];
                m_addr = p_addr[25*best +: 25];
                m_din  = p_din[8*best +: 8];
            end
            cyc++;
        end
        prev_strobe = init_n ? (sram_rd | sram_we) : 1'b0;
    end

    logic [2:0] keep = '0;
    bit         rnd = 0;

    // One clock of stimulus: drop a request the cycle after its ack unless it is being held.
    task automatic tick();
        @(posedge clk_sdram);
        #1;
        for (int n = 0; n < 3; n++) begin
            if (p_ack[n] && !keep[n]) begin
                p_req[n] = 1'b0;
            end else if (rnd && !p_req[n] && $urandom_range(0, 3) == 0) begin
                p_we[n]            = 1'($urandom);
                p_addr[25*n +: 25] = 25'($urandom);
                p_din[8*n +: 8]    = 8'($urandom);
                p_req[n]           = 1'b1;
            end
        end
    endtask

    task automatic req(input int n, input bit we, input logic [24:0] a, input logic [7:0] d);
        p_we[n]            = we;
        p_addr[25*n +: 25] = a;
        p_din[8*n +: 8]    = d;
        p_req[n]           = 1'b1;
    endtask

    task automatic wait_acks(input int target, input int budget, input string nm);
        int i = 0;
        while (ack_cnt < target && i < budget) begin
            tick();
            i++;
        end
        checks++;
        if (ack_cnt < target) begin
            errors++;
            $display("FAIL %s timeout acks=%0d needed=%0d", nm, ack_cnt, target);
        end
    endtask

    int a0;

    initial begin
        repeat (3) tick();
        init_n = 1'b1;
        repeat (5) tick();
        key = 8'h11;
        req(0, 1'b0, 25'h0000ABC, 8'h00);
        wait_acks(1, SU + 100, "startup_ack");
        chk("first_rise", first_rise, SU + 1);
        chk("startup_port", ack_port[0], 0);
        chk("startup_ack_cyc", ack_cyc[0], SU + 1 + SL);

        key = 8'h90;
        req(1, 1'b0, 25'h0001235, 8'h00);
        wait_acks(2, 200, "read_ack");
        chk("read_len", strobe_len, ST);
        chk("read_port", ack_port[1], 1);
        chk("read_lat", ack_cyc[1] - last_rise, SL);
        chk("read_dout", p_dout, 8'hA5);
        chk("read_addr", sram_addr, 25'h0001235);

        req(2, 1'b1, 25'h1FFFFFF, 8'h3C);
        wait_acks(3, 200, "write_ack");
        chk("write_len", strobe_len, ST);
        chk("write_port", ack_port[2], 2);
        chk("write_dout_held", p_dout, 8'hA5);
        chk("write_din", sram_din, 8'h3C);

        keep = 3'b111;
        for (int n = 0; n < 3; n++) req(n, 1'($urandom), 25'($urandom), 8'($urandom));
        wait_acks(9, 400, "fair_acks");
        p_req = 3'b000;
        keep  = 3'b000;
        for (int i = 0; i < 6; i++) begin
            chk("fair_port", ack_port[3+i], i % 3);
            if (i > 0) chk("fair_space", ack_cyc[3+i] - ack_cyc[2+i], SL + 2);
        end

        a0 = ack_cnt;
        req(0, 1'b0, 25'h0000777, 8'h00);
        repeat (20) tick();
        init_n = 1'b0;
        p_req  = 3'b000;
        repeat (3) tick();
        chk("rst_mid_no_ack", ack_cnt, a0);
        chk("rst_mid_busy", busy, 1);
        chk("rst_mid_addr", sram_addr, 0);
        init_n  = 1'b1;
        min_gap = 1000;
        keep    = 3'b001;
        req(0, 1'b0, 25'h0000777, 8'h00);
        wait_acks(a0 + 2, SU + 300, "b2b_acks");
        p_req = 3'b000;
        keep  = 3'b000;
        chk("restart_rise", first_rise, SU + 1);
        chk("restart_ack_cyc", ack_cyc[a0], SU + 1 + SL);
        chk("b2b_port", ack_port[a0+1], 0);
        chk("b2b_gap_ok", 32'(min_gap >= 2), 1);

        rnd = 1;
        wait_acks(ack_cnt + 40, 40 * (SL + 2) * 3, "random_acks");
        rnd = 0;
        repeat (200) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
